// File: rtl/instr_loader_if.sv
// Request channel and imem write port of the instruction loader.
// The host drives the master view and the loader presents the slave view.
interface instr_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_class, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Encodes field-level instruction requests into 32-bit MIPS words and writes
// them to instruction memory at consecutive (wrapping) word addresses.
module instr_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_loader_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_ovf
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [2:0] CLS_R    = 3'd0;
  localparam logic [2:0] CLS_LW   = 3'd1;
  localparam logic [2:0] CLS_SW   = 3'd2;
  localparam logic [2:0] CLS_BNE  = 3'd3;
  localparam logic [2:0] CLS_XORI = 3'd4;
  localparam logic [2:0] CLS_J    = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_ovf_q, err_ovf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        in_ready;
  logic        accept;
  logic        enc_legal;
  logic [31:0] enc_word;

  assign in_ready = (state_q == S_LOAD) && (count_q < DEPTH_CNT);
  assign accept   = bus.in_valid && in_ready;

  // Opcodes match the ones Control decodes; classes 6 and 7 have no encoding.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (bus.in_class)
      CLS_R:    enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd,
                            bus.in_shamt, bus.in_funct};
      CLS_LW:   enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      CLS_SW:   enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      CLS_BNE:  enc_word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
      CLS_XORI: enc_word = {6'b001110, bus.in_rs, bus.in_rt, bus.in_imm};
      CLS_J:    enc_word = {6'b000010, bus.in_target};
      default:  enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    addr_ptr_d    = addr_ptr_q;
    count_d       = count_q;
    err_illegal_d = err_illegal_q;
    err_ovf_d     = err_ovf_q;
    we_d          = 1'b0;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD;
          addr_ptr_d    = base_addr;
          count_d       = '0;
          err_illegal_d = 1'b0;
          err_ovf_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (enc_legal) begin
            we_d       = 1'b1;
            waddr_d    = addr_ptr_q;
            wdata_d    = enc_word;
            addr_ptr_d = addr_ptr_q + ADDR_ONE;
            count_d    = count_q + CNT_ONE;
          end else begin
            err_illegal_d = 1'b1;
          end
          // A last request that exactly fills memory is not an overflow.
          if (bus.in_last) begin
            state_d = S_DONE;
          end else if (count_d == DEPTH_CNT) begin
            state_d   = S_DONE;
            err_ovf_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_ptr_q    <= '0;
      count_q       <= '0;
      err_illegal_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      we_q          <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_ptr_q    <= addr_ptr_d;
      count_q       <= count_d;
      err_illegal_q <= err_illegal_d;
      err_ovf_q     <= err_ovf_d;
      we_q          <= we_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign count       = count_q;
  assign err_illegal = err_illegal_q;
  assign err_ovf     = err_ovf_q;

endmodule
